// File: rtl/tracker_pkg.sv
// Shared encodings for the line tracker: motion commands driven on the state
// port and the internal mode FSM states.
package tracker_pkg;

    typedef enum logic [2:0] {
        STOP    = 3'd0,
        FORWARD = 3'd1,
        BACK    = 3'd2,
        LEFT    = 3'd3,
        RIGHT   = 3'd4
    } motion_t;

    typedef enum logic [1:0] {
        TRACK  = 2'd0,
        SEARCH = 2'd1,
        HALT   = 2'd2
    } mode_t;

endpackage

// File: rtl/tracker_debounce.sv
// Stability filter: the output follows the input only after the input has held
// the same value for DEBOUNCE consecutive cycles. Built only with TRACKER_DEBOUNCE_EN.
module tracker_debounce #(
    parameter int WIDTH    = 3,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE);

    logic [WIDTH-1:0] prev;
    logic [CW-1:0]    stable_cnt;
    logic [CW-1:0]    next_cnt;

    // The cycle in which a new value first appears counts as its first stable cycle.
    always_comb begin
        next_cnt = stable_cnt;
        if (din != prev) begin
            next_cnt = CW'(1);
        end else if (stable_cnt != TARGET) begin
            next_cnt = stable_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '0;
            stable_cnt <= '0;
            dout       <= '0;
        end else begin
            prev       <= din;
            stable_cnt <= next_cnt;
            if (next_cnt == TARGET) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/line_tracker_fsm.sv
// Line-following motion controller: synchronises the sensors, optionally debounces
// them (macro TRACKER_DEBOUNCE_EN), classifies the line position and runs TRACK/SEARCH/HALT.
module line_tracker_fsm
    import tracker_pkg::*;
#(
    parameter int NUM_SENSORS  = 3,
    parameter int DEBOUNCE     = 4,
    parameter int LOST_TIMEOUT = 1000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] sensor,
    output logic [2:0]             state,
    output logic                   lost
);

    localparam int CENTRE = (NUM_SENSORS - 1) / 2;
    localparam int TW     = $clog2(LOST_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(LOST_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

    if ((NUM_SENSORS % 2) == 0 || NUM_SENSORS < 3 || NUM_SENSORS > 7) begin : g_bad_sensors
        $error("line_tracker_fsm: NUM_SENSORS must be odd and within 3..7");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_debounce
        $error("line_tracker_fsm: DEBOUNCE must be within 1..255");
    end
    if (LOST_TIMEOUT < 2) begin : g_bad_timeout
        $error("line_tracker_fsm: LOST_TIMEOUT must be at least 2");
    end

    logic [NUM_SENSORS-1:0] sync1, sync2, filtered;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sensor;
            sync2 <= sync1;
        end
    end

`ifdef TRACKER_DEBOUNCE_EN
    tracker_debounce #(
        .WIDTH    (NUM_SENSORS),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din   (sync2),
        .dout  (filtered)
    );
`else
    assign filtered = sync2;
`endif

    logic [2:0] left_cnt, right_cnt;
    logic       line_present;
    motion_t    direction;

    // Compare how many sensors see the line on each side of the centre sensor.
    always_comb begin
        left_cnt  = '0;
        right_cnt = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (i > CENTRE) begin
                left_cnt = left_cnt + 3'(filtered[i]);
            end else if (i < CENTRE) begin
                right_cnt = right_cnt + 3'(filtered[i]);
            end
        end
        line_present = |filtered;
        if (left_cnt > right_cnt) begin
            direction = LEFT;
        end else if (right_cnt > left_cnt) begin
            direction = RIGHT;
        end else begin
            direction = FORWARD;
        end
    end

    mode_t         mode, mode_next;
    motion_t       state_q, state_next;
    motion_t       last_dir, last_dir_next;
    logic          lost_q, lost_next;
    logic [TW-1:0] timer, timer_next;

    // last_dir holds BACK until a LEFT/RIGHT turn has been seen, so SEARCH backs up by default.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode     <= HALT;
            state_q  <= STOP;
            last_dir <= BACK;
            lost_q   <= 1'b0;
            timer    <= '0;
        end else begin
            mode     <= mode_next;
            state_q  <= state_next;
            last_dir <= last_dir_next;
            lost_q   <= lost_next;
            timer    <= timer_next;
        end
    end

    always_comb begin
        mode_next     = mode;
        state_next    = state_q;
        last_dir_next = last_dir;
        lost_next     = lost_q;
        timer_next    = timer;
        if (line_present && (direction == LEFT || direction == RIGHT)) begin
            last_dir_next = direction;
        end
        case (mode)
            TRACK: begin
                if (line_present) begin
                    state_next = direction;
                end else begin
                    mode_next  = SEARCH;
                    timer_next = '0;
                    state_next = last_dir;
                end
            end
            SEARCH: begin
                // A reappearing line takes priority over an expiring timeout.
                if (line_present) begin
                    mode_next  = TRACK;
                    timer_next = '0;
                    state_next = direction;
                end else if (timer == TIMER_LAST) begin
                    mode_next  = HALT;
                    state_next = STOP;
                    lost_next  = 1'b1;
                end else begin
                    state_next = last_dir;
                    if (timer != TIMER_MAX) begin
                        timer_next = timer + TW'(1);
                    end
                end
            end
            HALT: begin
                if (line_present) begin
                    mode_next  = TRACK;
                    timer_next = '0;
                    state_next = direction;
                    lost_next  = 1'b0;
                end else begin
                    state_next = STOP;
                end
            end
            default: begin
                mode_next  = HALT;
                state_next = STOP;
            end
        endcase
    end

    assign state = state_q;
    assign lost  = lost_q;

endmodule

// File: tb/tb_line_tracker_fsm.sv
// Directed bench for line_tracker_fsm: a 3-sensor instance (timeout 16) and a
// 5-sensor instance; latency expectations follow TRACKER_DEBOUNCE_EN.
module tb_line_tracker_fsm;

    localparam logic [2:0] S_STOP    = 3'd0;
    localparam logic [2:0] S_FORWARD = 3'd1;
    localparam logic [2:0] S_BACK    = 3'd2;
    localparam logic [2:0] S_LEFT    = 3'd3;
    localparam logic [2:0] S_RIGHT   = 3'd4;

`ifdef TRACKER_DEBOUNCE_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] sensor;
    logic [4:0] sensor5;
    logic [2:0] state3, state5;
    logic       lost3, lost5;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    line_tracker_fsm #(
        .NUM_SENSORS  (3),
        .DEBOUNCE     (4),
        .LOST_TIMEOUT (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sensor (sensor),
        .state  (state3),
        .lost   (lost3)
    );

    line_tracker_fsm #(
        .NUM_SENSORS  (5),
        .DEBOUNCE     (4),
        .LOST_TIMEOUT (16)
    ) dut5 (
        .clk    (clk),
        .reset  (reset),
        .sensor (sensor5),
        .state  (state5),
        .lost   (lost5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] v3, input logic [4:0] v5);
        sensor  = v3;
        sensor5 = v5;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] obs_state, input logic obs_lost,
                               input logic [2:0] exp_state, input logic exp_lost);
        vectors++;
        assert (obs_state === exp_state && obs_lost === exp_lost) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed state=%0d lost=%0d, expected state=%0d lost=%0d",
                   tag, obs_state, obs_lost, exp_state, exp_lost);
        end
    endtask

    logic [4:0] vec5 [6];
    logic [2:0] exp5 [6];

    initial begin
        vec5 = '{5'b00111, 5'b00100, 5'b10001, 5'b10011, 5'b11111, 5'b01000};
        exp5 = '{S_RIGHT, S_FORWARD, S_FORWARD, S_RIGHT, S_FORWARD, S_LEFT};

        reset = 1'b1;
        applyStimulus(3'b000, 5'b00000);
        repeat (3) step();
        checkOutput("reset_3", state3, lost3, S_STOP, 1'b0);
        checkOutput("reset_5", state5, lost5, S_STOP, 1'b0);
        reset = 1'b0;

        // No line after reset: the controller stays halted without flagging lost.
        for (int i = 0; i < 40; i++) begin
            step();
            checkOutput("idle_zero", state3, lost3, S_STOP, 1'b0);
        end

        applyStimulus(3'b010, 5'b00000);
        for (int i = 1; i <= LAT; i++) begin
            step();
            checkOutput("fwd_latency", state3, lost3, (i < LAT) ? S_STOP : S_FORWARD, 1'b0);
        end
        repeat (3) begin
            step();
            checkOutput("fwd_hold", state3, lost3, S_FORWARD, 1'b0);
        end

`ifdef TRACKER_DEBOUNCE_EN
        applyStimulus(3'b110, 5'b00000);
        repeat (3) step();
        applyStimulus(3'b010, 5'b00000);
        for (int i = 0; i < 12; i++) begin
            step();
            checkOutput("glitch_reject", state3, lost3, S_FORWARD, 1'b0);
        end
`endif

        // Line lost before any turn was seen: SEARCH backs up.
        applyStimulus(3'b000, 5'b00000);
        for (int i = 1; i <= LAT + 5; i++) begin
            step();
            checkOutput("search_back", state3, lost3, (i < LAT) ? S_FORWARD : S_BACK, 1'b0);
        end
        applyStimulus(3'b110, 5'b00000);
        for (int i = 1; i <= LAT; i++) begin
            step();
            checkOutput("reacquire_left", state3, lost3, (i < LAT) ? S_BACK : S_LEFT, 1'b0);
        end
        repeat (3) begin
            step();
            checkOutput("left_hold", state3, lost3, S_LEFT, 1'b0);
        end

        // Lose the line after LEFT: 16 SEARCH cycles steering LEFT, then HALT.
        applyStimulus(3'b000, 5'b00000);
        for (int i = 1; i <= LAT + 20; i++) begin
            step();
            checkOutput("timeout_left", state3, lost3,
                        (i < LAT + 16) ? S_LEFT : S_STOP, (i >= LAT + 16));
        end

        applyStimulus(3'b011, 5'b00000);
        for (int i = 1; i <= LAT; i++) begin
            step();
            checkOutput("halt_exit_right", state3, lost3,
                        (i < LAT) ? S_STOP : S_RIGHT, (i < LAT));
        end
        repeat (3) begin
            step();
            checkOutput("right_hold", state3, lost3, S_RIGHT, 1'b0);
        end

        // Line returns in the very cycle the timeout counter sits at 15.
        applyStimulus(3'b000, 5'b00000);
        for (int i = 1; i <= LAT + 19; i++) begin
            step();
            checkOutput("race_line_wins", state3, lost3,
                        (i < LAT + 16) ? S_RIGHT : S_FORWARD, 1'b0);
            if (i == 16) begin
                applyStimulus(3'b010, 5'b00000);
            end
        end

        applyStimulus(3'b010, 5'b11000);
        for (int i = 1; i <= LAT; i++) begin
            step();
            checkOutput("n5_left_latency", state5, lost5, (i < LAT) ? S_STOP : S_LEFT, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'b010, vec5[k]);
            repeat (LAT) step();
            checkOutput($sformatf("n5_vec%0d", k), state5, lost5, exp5[k], 1'b0);
        end

        // Reset in the middle of a search clears mode, counter and last_dir.
        applyStimulus(3'b000, 5'b00000);
        repeat (LAT + 5) step();
        checkOutput("pre_reset_search", state3, lost3, S_RIGHT, 1'b0);
        reset = 1'b1;
        step();
        checkOutput("mid_search_reset", state3, lost3, S_STOP, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("post_reset_idle", state3, lost3, S_STOP, 1'b0);
        end
        applyStimulus(3'b010, 5'b00000);
        repeat (LAT) step();
        checkOutput("post_reset_fwd", state3, lost3, S_FORWARD, 1'b0);
        applyStimulus(3'b000, 5'b00000);
        for (int i = 1; i <= LAT + 17; i++) begin
            step();
            checkOutput("post_reset_search", state3, lost3,
                        (i < LAT) ? S_FORWARD : ((i < LAT + 16) ? S_BACK : S_STOP),
                        (i >= LAT + 16));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_tracker_fsm.md
LINE_TRACKER_FSM -- requirements
Module: line_tracker_fsm

Interface
REQ-001 The block SHALL have parameter NUM_SENSORS, default 3, giving the sensor count (odd, 3..7).
REQ-002 The block SHALL have parameter DEBOUNCE, default 4, giving the stable cycles required before a sensor vector is accepted (1..255).
REQ-003 The block SHALL have parameter LOST_TIMEOUT, default 1000000, giving the SEARCH cycles before HALT (>=2).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port sensor, input, NUM_SENSORS bits: asynchronous line sensors, 1 = line seen; the MSB is the leftmost sensor.
REQ-007 Port state, output, 3 bits: registered motion command; encodings are STOP=0, FORWARD=1, BACK=2, LEFT=3, RIGHT=4.
REQ-008 Port lost, output, 1 bit: registered; 1 while in HALT after a timeout.

Function
REQ-009 sensor SHALL pass through a 2-flop synchroniser before any other use.
REQ-010 The filtered vector SHALL take the synchronised value once that value has been identical for DEBOUNCE consecutive cycles; the stability counter SHALL restart on any change.
REQ-011 Classification of the filtered vector F SHALL be as follows.
- L = popcount of the bits above centre; R = popcount of the bits below centre.
- F all-ones, or only the centre bit set -> FORWARD.
- L>R -> LEFT; R>L -> RIGHT; L==R with F nonzero -> FORWARD.
- F all-zero -> "no line".
REQ-012 The mode FSM SHALL have the states TRACK, SEARCH and HALT.
REQ-013 In TRACK, when a line is present, state SHALL be the classification; a LEFT or RIGHT result SHALL also be stored in last_dir, and a FORWARD result SHALL leave last_dir unchanged.
REQ-014 The TRACK->SEARCH transition SHALL occur on "no line", with the timeout counter cleared.
REQ-015 In SEARCH, state SHALL be last_dir, or BACK if last_dir has never been set since reset; the counter SHALL increment each cycle.
REQ-016 SEARCH SHALL go to TRACK on any line present, with the counter cleared.
REQ-017 SEARCH SHALL go to HALT when the counter reaches LOST_TIMEOUT-1 with no line; in HALT, state=STOP and lost=1.
REQ-018 If line-present and timeout expiry occur in the same cycle, the transition to TRACK SHALL win.
REQ-019 HALT SHALL go to TRACK on any line present; lost SHALL clear on the same edge.
REQ-020 The counter width SHALL be $clog2(LOST_TIMEOUT), and the counter SHALL saturate and never wrap.
REQ-021 Latency from a stable sensor change to state SHALL be 2+DEBOUNCE+1 edges with debounce, and 3 edges without it.

Reset
REQ-022 On reset, the block SHALL force the following.
- state=STOP, lost=0, mode=HALT.
- Synchroniser, filtered vector, stability counter and timeout counter = 0.
- last_dir = unset.
REQ-023 Because mode resets to HALT, the output SHALL stay STOP until a line is first detected.
REQ-024 Reset asserted mid-SEARCH or mid-debounce SHALL abort it within the same edge, with no residual count.

Configuration
REQ-025 The block SHALL support macro TRACKER_DEBOUNCE_EN.
- Defined: debounce per REQ-010.
- Undefined: the filtered vector equals the synchroniser output, the DEBOUNCE parameter is ignored, and no counter is built.

Structure
REQ-026 Package tracker_pkg SHALL hold the state encodings (STOP..RIGHT) and the mode enum (TRACK, SEARCH, HALT).
REQ-027 The debounce logic SHALL be a sub-module tracker_debounce (parameters WIDTH, DEBOUNCE), instantiated only under TRACKER_DEBOUNCE_EN.

Verification
Scenarios REQ-028 to REQ-032 use NUM_SENSORS=3, DEBOUNCE=4, LOST_TIMEOUT=16.
REQ-028 Reset then sensor=3'b000 for 40 cycles -> state=STOP throughout, lost=0.
REQ-029 sensor=3'b010 held -> FORWARD exactly 7 edges after the change; a 3-cycle glitch to 3'b110 -> no change in state.
REQ-030 3'b110 then 3'b000 -> LEFT, then SEARCH outputs LEFT for 16 cycles, then STOP with lost=1.
REQ-031 In HALT, apply 3'b011 -> RIGHT and lost=0 on the same edge, 7 edges after the change.
REQ-032 A line reappears on the cycle the timeout counter reaches 15 -> TRACK, with lost never asserted.
REQ-033 With NUM_SENSORS=5 and the macro undefined, sensor=5'b11000 -> LEFT after 3 edges; 5'b00111 -> RIGHT.
